// File: rtl/calc_pkg.sv
// Shared definitions for the calculator op sequencer: opcode defaults,
// FSM state encoding and the per-opcode EXEC latency lookup.
package calc_pkg;

  localparam logic [3:0] NOP_OP_DEF  = 4'h0;
  localparam logic [3:0] MUL_OP_DEF  = 4'h3;
  localparam logic [3:0] DIV_OP_DEF  = 4'h4;
  localparam logic [3:0] CLR_OP_DEF  = 4'hF;
  localparam int         MUL_LAT_DEF = 4;
  localparam int         DIV_LAT_DEF = 16;
  localparam int         CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Opcodes are passed zero-extended to 8 bits so any NSEL up to 256 fits.
  function automatic logic [CNT_W-1:0] op_latency(
    input logic [7:0]       op,
    input logic [7:0]       mul_op,
    input logic [CNT_W-1:0] mul_lat,
    input logic [7:0]       div_op,
    input logic [CNT_W-1:0] div_lat
  );
    if (op == mul_op)      return mul_lat;
    else if (op == div_op) return div_lat;
    else                   return CNT_W'(1);
  endfunction

endpackage

// File: rtl/calc_onehot_decode.sv
// Combinational opcode-to-one-hot decoder; output is all-zero when disabled,
// so it can never produce a multi-hot pattern.
module calc_onehot_decode #(
  parameter int NSEL = 16,
  parameter int OPW  = $clog2(NSEL)
) (
  input  logic [OPW-1:0]  i_op,
  input  logic            i_en,
  output logic [NSEL-1:0] o_hot
);

  genvar gi;
  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_bit
      assign o_hot[gi] = i_en && (i_op == OPW'(gi));
    end
  endgenerate

endmodule

// File: rtl/calc_op_sequencer.sv
// Command sequencer for the calculator datapath: accepts one opcode/operand,
// drives the one-hot result mux for a per-opcode latency, captures into the
// accumulator and returns a response.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter int         NSEL    = 16,
  parameter logic [3:0] MUL_OP  = MUL_OP_DEF,
  parameter int         MUL_LAT = MUL_LAT_DEF,
  parameter logic [3:0] DIV_OP  = DIV_OP_DEF,
  parameter int         DIV_LAT = DIV_LAT_DEF,
  parameter logic [3:0] NOP_OP  = NOP_OP_DEF,
  parameter logic [3:0] CLR_OP  = CLR_OP_DEF,
  localparam int        OPW     = $clog2(NSEL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [NSEL-1:0]  hotselect,
  input  logic [WIDTH-1:0] muxout,
  input  logic             alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_error
);

  generate
    if (MUL_LAT < 1 || MUL_LAT > 255 || DIV_LAT < 1 || DIV_LAT > 255) begin : g_bad_lat
      $error("calc_op_sequencer: MUL_LAT/DIV_LAT must be in 1..255");
    end
    if (MUL_OP == NOP_OP || MUL_OP == CLR_OP || DIV_OP == NOP_OP || DIV_OP == CLR_OP) begin : g_bad_op
      $error("calc_op_sequencer: MUL_OP/DIV_OP must not alias NOP_OP/CLR_OP");
    end
  endgenerate

  localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_op_b;
  logic [NSEL-1:0]  r_hotsel;
  logic             r_rsp_valid;
  logic             r_rsp_error;

  logic             w_is_nop;
  logic             w_is_clr;
  logic [CNT_W-1:0] w_lat;
  logic [NSEL-1:0]  w_hot_dec;

  assign w_is_nop = (8'(cmd_opcode) == 8'(NOP_OP));
  assign w_is_clr = (8'(cmd_opcode) == 8'(CLR_OP));
  assign w_lat    = op_latency(8'(cmd_opcode), 8'(MUL_OP), MUL_LAT_C, 8'(DIV_OP), DIV_LAT_C);

  calc_onehot_decode #(
    .NSEL (NSEL)
  ) u_decode (
    .i_op  (cmd_opcode),
    .i_en  (1'b1),
    .o_hot (w_hot_dec)
  );

  assign cmd_ready  = (r_state == ST_IDLE) && rst_n;
  assign op_a       = r_acc;
  assign op_b       = r_op_b;
  assign hotselect  = r_hotsel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_acc;
  assign rsp_error  = r_rsp_error;

  // The hotselect register doubles as the latched opcode while in EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_op_b      <= '0;
      r_hotsel    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op_b      <= cmd_operand;
            r_rsp_error <= 1'b0;
            if (w_is_nop) begin
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else if (w_is_clr) begin
              r_acc       <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_hotsel <= w_hot_dec;
              r_cnt    <= w_lat - CNT_W'(1);
              r_state  <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            // A datapath error leaves the accumulator untouched.
            if (!alu_err) r_acc <= muxout;
            r_rsp_error <= alu_err;
            r_hotsel    <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_hotsel    <= '0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed, table-driven bench for calc_op_sequencer plus hand-written
// reset sequences.
module tb_calc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_operand;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [15:0] hotselect;
  logic [31:0] muxout;
  logic        alu_err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_error;

  always #5 clk = ~clk;

  calc_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_operand (cmd_operand),
    .op_a        (op_a),
    .op_b        (op_b),
    .hotselect   (hotselect),
    .muxout      (muxout),
    .alu_err     (alu_err),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_error   (rsp_error)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] operand;
    logic [31:0] mux;
    logic        err;
    int          stall;
    int          exp_lat;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input logic [31:0] prev_acc);
    int          hot;
    logic [15:0] exp_hot;
    logic [15:0] one;
    one     = 16'd1;
    exp_hot = one << v.op;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    chk("op_a_before", op_a, prev_acc);
    cmd_valid   = 1'b1;
    cmd_opcode  = v.op;
    cmd_operand = v.operand;
    muxout      = v.mux;
    alu_err     = v.err;
    rsp_ready   = 1'b0;
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_operand = 32'h0;
    chk("op_b_latched", op_b, v.operand);
    hot = 0;
    while (rsp_valid !== 1'b1 && hot < 40) begin
      chk("hotselect_exec", 32'(hotselect), 32'(exp_hot));
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      chk("op_a_stable", op_a, prev_acc);
      chk("op_b_stable", op_b, v.operand);
      hot++;
      @(negedge clk);
    end
    chk("rsp_valid_arrives", 32'(rsp_valid), 32'd1);
    chk("hot_cycles", 32'(hot), 32'(v.exp_lat));
    chk("hotselect_resp", 32'(hotselect), 32'd0);
    chk("rsp_result", rsp_result, v.exp_res);
    chk("rsp_error", 32'(rsp_error), 32'(v.exp_err));
    repeat (v.stall) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_result", rsp_result, v.exp_res);
      chk("stall_error", 32'(rsp_error), 32'(v.exp_err));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    $display("vec %0d op=%0h operand=%0h lat=%0d result=%0h err=%0b", idx, v.op, v.operand, hot,
             rsp_result, rsp_error);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    vecs[0] = '{4'h1, 32'd5,  32'd5,          1'b0, 0, 1,  32'd5,          1'b0};
    vecs[1] = '{4'h4, 32'd3,  32'd7,          1'b0, 0, 16, 32'd7,          1'b0};
    vecs[2] = '{4'h4, 32'd0,  32'd99,         1'b1, 0, 16, 32'd7,          1'b1};
    vecs[3] = '{4'h3, 32'd3,  32'd21,         1'b0, 2, 4,  32'd21,         1'b0};
    vecs[4] = '{4'h0, 32'd77, 32'h0000AAAA,   1'b0, 0, 0,  32'd21,         1'b0};
    vecs[5] = '{4'h2, 32'd1,  32'hDEADBEEF,   1'b0, 5, 1,  32'hDEADBEEF,   1'b0};
    vecs[6] = '{4'hF, 32'd0,  32'h00005555,   1'b0, 0, 0,  32'd0,          1'b0};
    vecs[7] = '{4'hE, 32'd8,  32'h12345678,   1'b1, 0, 1,  32'd0,          1'b1};
    vecs[8] = '{4'hE, 32'd8,  32'h12345678,   1'b0, 0, 1,  32'h12345678,   1'b0};

    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_opcode  = 4'h0;
    cmd_operand = 32'h0;
    muxout      = 32'h0;
    alu_err     = 1'b0;
    rsp_ready   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hotselect", 32'(hotselect), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready_high", 32'(cmd_ready), 32'd1);
    $display("reset: hotselect=%0h rsp_valid=%0b op_a=%0h cmd_ready=%0b", hotselect, rsp_valid, op_a,
             cmd_ready);

    prev = 32'd0;
    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i], prev);
      prev = vecs[i].exp_res;
    end

    // Reset in the middle of a MUL command, on its second EXEC cycle.
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_opcode  = 4'h3;
    cmd_operand = 32'd6;
    muxout      = 32'd42;
    alu_err     = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_exec_hot1", 32'(hotselect), 32'h0008);
    @(negedge clk);
    chk("mid_exec_hot2", 32'(hotselect), 32'h0008);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_hotselect", 32'(hotselect), 32'd0);
    chk("mid_rst_acc", op_a, 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_hot", 32'(hotselect), 32'd0);
      chk("post_rst_acc", rsp_result, 32'd0);
    end
    rsp_ready = 1'b0;
    $display("mid-exec reset: hotselect=%0h op_a=%0h rsp_valid=%0b", hotselect, op_a, rsp_valid);

    run_vec(9, vecs[0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
